// File: rtl/touch_adc_reader_pkg.sv
// Shared constants and state encoding for the touch-screen ADC reader.
package touch_adc_reader_pkg;
  localparam logic [7:0] CMD_X           = 8'h92;
  localparam logic [7:0] CMD_Y           = 8'hD2;
  localparam logic [4:0] FRAME_PERIODS   = 5'd24;
  localparam logic [4:0] DATA_FIRST_EDGE = 5'd10;
  localparam logic [4:0] DATA_LAST_EDGE  = 5'd21;

  typedef enum logic [2:0] {
    IDLE,
    FRAME_X,
    CS_GAP,
    FRAME_Y,
    REPORT,
    WAIT_GAP
  } state_t;
endpackage

// File: rtl/touch_adc_reader_spi_frame.sv
// One 24-period serial frame: 8-bit command out MSB first, 12-bit result in.
// done is combinational and is high on the clock where CS_n rises.
module adc_spi_frame
  import touch_adc_reader_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  command,
  input  logic        dout,
  output logic        busy,
  output logic        done,
  output logic [11:0] result,
  output logic        cs_n,
  output logic        dclk,
  output logic        din
);
  logic [15:0] div_cnt;
  logic [4:0]  period_cnt;
  logic [7:0]  cmd_sr;
  logic        phase_end;

  assign busy      = ~cs_n;
  assign phase_end = busy && (div_cnt == 16'(CLK_DIV - 1));
  assign done      = phase_end && dclk && (period_cnt == FRAME_PERIODS - 5'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cs_n       <= 1'b1;
      dclk       <= 1'b0;
      din        <= 1'b0;
      div_cnt    <= '0;
      period_cnt <= '0;
      cmd_sr     <= '0;
      result     <= '0;
    end else if (!busy) begin
      if (start) begin
        cs_n       <= 1'b0;
        dclk       <= 1'b0;
        din        <= command[7];
        div_cnt    <= '0;
        period_cnt <= '0;
        cmd_sr     <= command;
        result     <= '0;
      end
    end else if (phase_end) begin
      div_cnt <= '0;
      dclk    <= ~dclk;
      if (!dclk) begin
        // period_cnt holds completed periods, so rising edge number is period_cnt+1
        if (period_cnt >= DATA_FIRST_EDGE - 5'd1 && period_cnt <= DATA_LAST_EDGE - 5'd1)
          result <= {result[10:0], dout};
      end else begin
        period_cnt <= period_cnt + 5'd1;
        cmd_sr     <= {cmd_sr[6:0], 1'b0};
        din        <= cmd_sr[6];
        if (period_cnt == FRAME_PERIODS - 5'd1) begin
          cs_n <= 1'b1;
          din  <= 1'b0;
        end
      end
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end
endmodule

// File: rtl/touch_adc_reader.sv
// Touch controller front end: samples X then Y while the pen is down and
// publishes the pair with a one-cycle new_coord pulse.
module touch_adc_reader
  import touch_adc_reader_pkg::*;
#(
  parameter int CLK_DIV    = 25,
  parameter int SAMPLE_GAP = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iPENIRQ_n,
  input  logic        iADC_DOUT,
  output logic        oADC_CS_n,
  output logic        oADC_DCLK,
  output logic        oADC_DIN,
  output logic [11:0] x_coord,
  output logic [11:0] y_coord,
  output logic        new_coord
);
  logic        pen_meta;
  logic        pen_sync;
  logic        touched;
  state_t      state;
  logic [31:0] cnt;
  logic [11:0] x_sample;
  logic        frame_start;
  logic        frame_busy;
  logic        frame_done;
  logic [11:0] frame_result;
  logic [7:0]  frame_cmd;
  logic        div_last;
  logic        gap_last;

  assign touched  = ~pen_sync;
  assign div_last = (cnt == 32'(CLK_DIV - 1));
  assign gap_last = (cnt == 32'(SAMPLE_GAP - 1));

  always_comb begin
    frame_start = !frame_busy &&
                  ((state == IDLE && touched) ||
                   (state == CS_GAP && div_last) ||
                   (state == WAIT_GAP && gap_last && touched));
    frame_cmd   = (state == CS_GAP) ? CMD_Y : CMD_X;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pen_meta <= 1'b1;
      pen_sync <= 1'b1;
    end else begin
      pen_meta <= iPENIRQ_n;
      pen_sync <= pen_meta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      x_sample  <= '0;
      x_coord   <= '0;
      y_coord   <= '0;
      new_coord <= 1'b0;
    end else begin
      new_coord <= 1'b0;
      case (state)
        IDLE:    if (touched) state <= FRAME_X;
        FRAME_X: if (frame_done) begin
          x_sample <= frame_result;
          cnt      <= '0;
          state    <= CS_GAP;
        end
        CS_GAP: begin
          cnt <= cnt + 32'd1;
          if (div_last) begin
            cnt   <= '0;
            state <= FRAME_Y;
          end
        end
        FRAME_Y: if (frame_done) state <= REPORT;
        REPORT: begin
          // a release anywhere in the pair is only honoured here, so the pair is dropped whole
          if (touched) begin
            x_coord   <= x_sample;
            y_coord   <= frame_result;
            new_coord <= 1'b1;
          end
          cnt   <= '0;
          state <= WAIT_GAP;
        end
        WAIT_GAP: begin
          cnt <= cnt + 32'd1;
          if (gap_last) begin
            cnt   <= '0;
            state <= touched ? FRAME_X : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  adc_spi_frame #(.CLK_DIV(CLK_DIV)) u_frame (
    .clock   (clock),
    .reset   (reset),
    .start   (frame_start),
    .command (frame_cmd),
    .dout    (iADC_DOUT),
    .busy    (frame_busy),
    .done    (frame_done),
    .result  (frame_result),
    .cs_n    (oADC_CS_n),
    .dclk    (oADC_DCLK),
    .din     (oADC_DIN)
  );
endmodule
